// File: rtl/melody_sequencer.sv
// melody_sequencer: plays a 16-entry note table through an internal square-wave
// tone generator. Each entry is {dur[7:0], div[14:0]}. dur is the length in beats,
// and 0 marks the end of the table. div is the half-period in clk cycles, and 0 means
// a rest. A silent gap of GAP_CYCLES follows every note.
//
// Ports:
//   clk         system clock
//   rst_n       asynchronous active-low reset
//   start       pulse: begin playback at entry 0 (ignored while busy)
//   stop        abort playback and return to idle (wins over start)
//   loop_en     sampled at end of table: restart from entry 0 when 1
//   wr_en       note table write strobe (any state)
//   wr_addr     note table write address
//   wr_data     {dur, div} entry data
//   half_period divider of the sounding note (0 when idle/rest/gap)
//   tone_en     1 while a non-rest note sounds
//   speaker     square wave output
//   busy        1 whenever not idle
//   note_idx    index of the current table entry
//   done        one-cycle pulse on normal completion
module melody_sequencer #(
  parameter int unsigned BEAT_CYCLES = 3125000,
  parameter int unsigned GAP_CYCLES  = 250000,
  parameter int unsigned DEPTH       = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        stop,
  input  logic        loop_en,
  input  logic        wr_en,
  input  logic [3:0]  wr_addr,
  input  logic [22:0] wr_data,
  output logic [14:0] half_period,
  output logic        tone_en,
  output logic        speaker,
  output logic        busy,
  output logic [3:0]  note_idx,
  output logic        done
);

  localparam int unsigned BW = (BEAT_CYCLES > 1) ? $clog2(BEAT_CYCLES) : 1;
  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {IDLE, FETCH, PLAY, GAP, DONE} state_t;

  state_t        state, state_next;
  logic [3:0]    idx_next;
  logic [22:0]   table_mem [DEPTH];
  logic [22:0]   entry;
  logic [7:0]    entry_dur;
  logic [14:0]   entry_div;
  logic [BW-1:0] beat_cnt;
  logic [7:0]    beats_left;
  logic [GW-1:0] gap_cnt;
  logic [14:0]   tone_cnt;
  logic          note_end;
  logic          advance;

  always_ff @(posedge clk) begin
    if (wr_en) table_mem[wr_addr] <= wr_data;
  end

  assign entry     = table_mem[note_idx];
  assign entry_dur = entry[22:15];
  assign entry_div = entry[14:0];
  assign note_end  = (beat_cnt == '0) && (beats_left == '0);
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      note_idx <= '0;
    end else begin
      state    <= state_next;
      note_idx <= idx_next;
    end
  end

  always_comb begin
    state_next = state;
    idx_next   = note_idx;
    advance    = 1'b0;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_next = FETCH;
          idx_next   = '0;
        end
      end
      FETCH: begin
        if (entry_dur == '0) begin
          // An end marker at entry 0 is an empty table: finish even when looping.
          if (loop_en && (note_idx != '0)) idx_next = '0;
          else state_next = DONE;
        end else begin
          state_next = PLAY;
        end
      end
      PLAY: begin
        if (note_end) begin
          if (GAP_CYCLES != 0) state_next = GAP;
          else advance = 1'b1;
        end
      end
      GAP: begin
        if (gap_cnt == '0) advance = 1'b1;
      end
      DONE: begin
        state_next = IDLE;
        idx_next   = '0;
      end
      default: state_next = IDLE;
    endcase
    if (advance) begin
      if (note_idx == 4'(DEPTH - 1)) begin
        if (loop_en) begin
          idx_next   = '0;
          state_next = FETCH;
        end else begin
          state_next = DONE;
        end
      end else begin
        idx_next   = note_idx + 4'd1;
        state_next = FETCH;
      end
    end
    if (stop) begin
      state_next = IDLE;
      idx_next   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      half_period <= '0;
      tone_en     <= 1'b0;
      speaker     <= 1'b0;
      beat_cnt    <= '0;
      beats_left  <= '0;
      gap_cnt     <= '0;
      tone_cnt    <= '0;
    end else if (stop) begin
      half_period <= '0;
      tone_en     <= 1'b0;
      speaker     <= 1'b0;
      beat_cnt    <= '0;
      beats_left  <= '0;
      gap_cnt     <= '0;
      tone_cnt    <= '0;
    end else begin
      unique case (state)
        FETCH: begin
          if (entry_dur != '0) begin
            half_period <= entry_div;
            tone_en     <= (entry_div != '0);
            speaker     <= 1'b0;
            tone_cnt    <= entry_div - 15'd1;
            beat_cnt    <= BEAT_LAST;
            beats_left  <= entry_dur - 8'd1;
          end
        end
        PLAY: begin
          if (tone_en) begin
            if (tone_cnt == '0) begin
              speaker  <= ~speaker;
              tone_cnt <= half_period - 15'd1;
            end else begin
              tone_cnt <= tone_cnt - 15'd1;
            end
          end
          // Nested beat/cycle counters; the final-cycle clear comes last so it
          // overrides the tone generator update above.
          if (beat_cnt != '0) begin
            beat_cnt <= beat_cnt - 1'b1;
          end else if (beats_left != '0) begin
            beat_cnt   <= BEAT_LAST;
            beats_left <= beats_left - 8'd1;
          end else begin
            half_period <= '0;
            tone_en     <= 1'b0;
            speaker     <= 1'b0;
            gap_cnt     <= GAP_LAST;
          end
        end
        GAP: begin
          if (gap_cnt != '0) gap_cnt <= gap_cnt - 1'b1;
        end
        default: begin
          tone_en <= 1'b0;
          speaker <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed self-checking bench for melody_sequencer with BEAT_CYCLES=10, GAP_CYCLES=2.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_melody_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, stop, loop_en, wr_en;
  logic [3:0]  wr_addr;
  logic [22:0] wr_data;
  logic [14:0] half_period;
  logic        tone_en, speaker, busy, done;
  logic [3:0]  note_idx;

  int errors = 0;
  int checks = 0;

  melody_sequencer #(.BEAT_CYCLES(10), .GAP_CYCLES(2), .DEPTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .loop_en(loop_en),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .half_period(half_period), .tone_en(tone_en), .speaker(speaker),
    .busy(busy), .note_idx(note_idx), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input int addr, input int dur, input int div);
    wr_en   = 1'b1;
    wr_addr = 4'(addr);
    wr_data = {8'(dur), 15'(div)};
    tick(1);
    wr_en   = 1'b0;
  endtask

  task automatic expect_idle(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_tone"}, 32'(tone_en), 0);
    chk({tag, "_spk"}, 32'(speaker), 0);
    chk({tag, "_hp"}, 32'(half_period), 0);
    chk({tag, "_idx"}, 32'(note_idx), 0);
  endtask

  task automatic expect_fetch(input int idx);
    chk("fetch_busy", 32'(busy), 1);
    chk("fetch_idx", 32'(note_idx), 32'(idx));
    chk("fetch_tone", 32'(tone_en), 0);
    chk("fetch_hp", 32'(half_period), 0);
    chk("fetch_done", 32'(done), 0);
    tick(1);
  endtask

  // Checks PLAY cycles k0..k1-1 of a note (k counts from the first PLAY cycle).
  task automatic expect_play(input int idx, input int div, input int k0, input int k1);
    for (int k = k0; k < k1; k++) begin
      chk("play_tone", 32'(tone_en), (div != 0) ? 1 : 0);
      chk("play_hp", 32'(half_period), 32'(div));
      chk("play_spk", 32'(speaker), (div == 0) ? 0 : 32'((k / div) % 2));
      chk("play_idx", 32'(note_idx), 32'(idx));
      chk("play_done", 32'(done), 0);
      tick(1);
    end
  endtask

  task automatic expect_gap();
    for (int g = 0; g < 2; g++) begin
      chk("gap_tone", 32'(tone_en), 0);
      chk("gap_spk", 32'(speaker), 0);
      chk("gap_hp", 32'(half_period), 0);
      chk("gap_busy", 32'(busy), 1);
      chk("gap_done", 32'(done), 0);
      tick(1);
    end
  endtask

  task automatic expect_done();
    chk("done_pulse", 32'(done), 1);
    chk("done_tone", 32'(tone_en), 0);
    chk("done_busy", 32'(busy), 1);
    tick(1);
    chk("done_clear", 32'(done), 0);
    chk("done_idle", 32'(busy), 0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; loop_en = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    tick(2);
    expect_idle("reset");
    rst_n = 1'b1;
    tick(1);

    // Two notes then end marker, no loop.
    wr(0, 2, 3); wr(1, 1, 0); wr(2, 0, 0);
    pulse_start();
    expect_fetch(0); expect_play(0, 3, 0, 20); expect_gap();
    expect_fetch(1); expect_play(1, 0, 0, 10); expect_gap();
    expect_fetch(2);
    expect_done();

    // Looping; rewrite entry 0 mid-note and pulse start (ignored), then stop.
    loop_en = 1'b1;
    pulse_start();
    expect_fetch(0); expect_play(0, 3, 0, 5);
    wr_en = 1'b1; wr_addr = 4'd0; wr_data = {8'd2, 15'd5}; start = 1'b1;
    expect_play(0, 3, 5, 6);
    wr_en = 1'b0; start = 1'b0;
    expect_play(0, 3, 6, 20); expect_gap();
    expect_fetch(1); expect_play(1, 0, 0, 10); expect_gap();
    expect_fetch(2);
    expect_fetch(0); expect_play(0, 5, 0, 20);
    chk("pre_stop_gap", 32'(busy), 1);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    expect_idle("stop");
    tick(1);
    expect_idle("stop_after");

    // start and stop together: stop wins.
    start = 1'b1; stop = 1'b1;
    tick(1);
    start = 1'b0; stop = 1'b0;
    expect_idle("start_stop");

    // Empty table with loop enabled still completes.
    wr(0, 0, 7);
    pulse_start();
    chk("empty_fetch_busy", 32'(busy), 1);
    chk("empty_fetch_tone", 32'(tone_en), 0);
    tick(1);
    expect_done();
    tick(1);
    chk("empty_no_repeat", 32'(done), 0);

    // Full table of one-beat div=1 notes, no loop.
    loop_en = 1'b0;
    for (int i = 0; i < 16; i++) wr(i, 1, 1);
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      expect_fetch(i); expect_play(i, 1, 0, 10); expect_gap();
    end
    expect_done();

    // Same table looping: index wraps 15 -> 0.
    loop_en = 1'b1;
    pulse_start();
    for (int i = 0; i < 16; i++) begin
      expect_fetch(i); expect_play(i, 1, 0, 10); expect_gap();
    end
    expect_fetch(0);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    expect_idle("wrap_stop");

    // Asynchronous reset mid-note while speaker is high.
    loop_en = 1'b0;
    wr(0, 2, 3); wr(1, 0, 0);
    pulse_start();
    expect_fetch(0); expect_play(0, 3, 0, 4);
    chk("pre_reset_spk", 32'(speaker), 1);
    #2 rst_n = 1'b0;
    #1 expect_idle("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    expect_idle("post_reset");
    pulse_start();
    expect_fetch(0); expect_play(0, 3, 0, 20); expect_gap();
    expect_fetch(1);
    expect_done();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/melody_sequencer.md
Name: melody_sequencer

Overview:
Plays a stored note sequence by stepping through a 16-entry note table, holding each note for a programmed number of beats. Drives an internal square-wave tone generator (half-period clock divider) and exposes the current divider value for other audio blocks. Sits between host/button logic and the speaker pin. It is the controller that sequences the fixed-pitch tone dividers.

Parameters:
BEAT_CYCLES, 3125000, clk cycles per beat (8 beats/s at 25 MHz); must be >= 1
GAP_CYCLES, 250000, silent clk cycles inserted after every note (0 = no gap)
DEPTH, 16, note table entries (address width 4)

Ports:
clk  in  1  system clock, 25 MHz nominal
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: begin playback at entry 0; ignored while busy
stop  in  1  level/pulse: abort playback
loop_en  in  1  sampled at end of table: restart from entry 0 when 1
wr_en  in  1  note table write strobe
wr_addr  in  4  note table write address
wr_data  in  23  {dur[7:0], div[14:0]}; dur = beats (0 = end marker), div = half-period in clk cycles (0 = rest)
half_period  out  15  divider of current note (0 when idle/rest/gap)
tone_en  out  1  1 while a non-rest note sounds
speaker  out  1  square wave output
busy  out  1  1 in any state except IDLE
note_idx  out  4  index of current table entry
done  out  1  one-cycle pulse when playback completes normally

Behaviour:
- Reset (async, rst_n=0): state IDLE; half_period=0, tone_en=0, speaker=0, busy=0, note_idx=0, done=0, all counters 0. Table contents undefined after reset; not cleared.
- Table: synchronous write on wr_en at posedge, any state. Entry data latched only in FETCH; rewriting the playing entry does not alter the current note.
- States: IDLE, FETCH, PLAY, GAP, DONE.
- IDLE: start=1 -> FETCH next cycle, note_idx=0.
- FETCH (1 cycle): read entry[note_idx].
  - dur==0: if loop_en=1 and note_idx!=0 -> note_idx=0, stay FETCH; else -> DONE. Empty table (entry 0 dur 0) always reaches DONE, even with loop_en.
  - dur!=0 -> PLAY; half_period<=div; tone_en<=(div!=0); beat counter<=BEAT_CYCLES-1; beats remaining<=dur-1.
- PLAY: beat counter decrements each cycle; at 0 with beats remaining 0 -> GAP (or straight to advance if GAP_CYCLES=0); else reload BEAT_CYCLES-1 and decrement beats remaining. Note lasts exactly dur*BEAT_CYCLES cycles.
- GAP: tone_en=0, half_period=0, speaker=0 for exactly GAP_CYCLES cycles.
- Advance: note_idx==DEPTH-1 treated as end marker (loop_en -> note_idx=0, FETCH; else DONE); otherwise note_idx+1, FETCH.
- DONE: done=1 for one cycle, tone_en=0, -> IDLE.
- Tone generator: on PLAY entry with div!=0, counter<=div-1, speaker<=0; each cycle counter==0 -> speaker toggles, counter<=half_period-1; else decrement. div=1 toggles every cycle. speaker forced 0 when tone_en=0.
- stop=1: from any state -> IDLE next cycle; outputs return to reset values (note_idx=0); no done pulse. start and stop in same cycle: stop wins.
- start while busy: ignored, no restart.
- Widths: dur*BEAT_CYCLES never computed as a product; nested counters only. Beat counter wide enough for BEAT_CYCLES-1 (22 bits at default).

Test Plan:
- BEAT_CYCLES=10, GAP_CYCLES=2; table {dur 2,div 3},{dur 1,div 0},{dur 0}; start -> tone_en high 20 cycles with speaker period 6, speaker 0 for 2 gap cycles, rest 10 cycles tone_en=0, gap 2, done pulses once, busy falls next cycle.
- Same table with loop_en=1 -> note_idx sequence 0,1,0,1,... no done; then stop -> busy=0, speaker=0, tone_en=0 next cycle, no done pulse.
- Entry 0 dur 0 with loop_en=1, start -> DONE within 2 cycles, done pulse once, no tone.
- All 16 entries dur 1, div 1, loop_en=0 -> speaker toggles every cycle, note_idx reaches 15, done after 16 notes; loop_en=1 -> note_idx wraps 15->0.
- Rewrite entry 0 div 3->5 mid-note -> current note keeps period 6; next loop pass period 10. start during playback -> ignored.
- Assert rst_n low mid-PLAY (asynchronous, between edges) -> all outputs 0 immediately; start after release plays from entry 0.
